// File: rtl/gb_oam_pkg.sv
// Shared OAM types and constants for the DMA engine and the mode-2 object scanner.
package gb_oam_pkg;

  localparam int unsigned OAM_NUM_OBJS = 40;
  localparam int unsigned OAM_SCAN_MAX = 10;
  localparam int unsigned OAM_IDX_W    = 6;
  localparam int unsigned PPU_IDX_W    = 7;
  localparam int unsigned BUF_CNT_W    = 4;
  localparam int unsigned LINE_W       = 9;

  // One OAM entry; y is OAM byte 0.
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] attr;
  } oam_obj_t;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_FETCH = 2'd1,
    SCAN_EVAL  = 2'd2,
    SCAN_DONE  = 2'd3
  } scan_state_t;

  // Object covers the line when y <= ly+16 < y+height, evaluated in 9 bits.
  function automatic logic obj_on_line(input logic [7:0] ly, input logic tall,
                                       input logic [7:0] y);
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] top;
    logic [LINE_W-1:0] bot;
    line = LINE_W'(ly) + LINE_W'(16);
    top  = LINE_W'(y);
    bot  = top + (tall ? LINE_W'(16) : LINE_W'(8));
    return (line >= top) && (line < bot);
  endfunction

endpackage

// File: rtl/gb_oam_scan_buf.sv
// Ten-slot selected-object buffer: one write port, one combinational read port, no reset.
module gb_oam_scan_buf
  import gb_oam_pkg::*;
(
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [BUF_CNT_W-1:0] i_wr_idx,
  input  oam_obj_t             i_wr_obj,
  input  logic [OAM_IDX_W-1:0] i_wr_oam_idx,
  input  logic [BUF_CNT_W-1:0] i_rd_idx,
  output oam_obj_t             o_rd_obj,
  output logic [OAM_IDX_W-1:0] o_rd_oam_idx
);

  oam_obj_t             r_obj_mem [OAM_SCAN_MAX];
  logic [OAM_IDX_W-1:0] r_idx_mem [OAM_SCAN_MAX];
  logic [BUF_CNT_W-1:0] w_rd_sel;
  logic                 w_wr_ok;

  // Out-of-range slots fold onto slot 0; callers treat those reads as stale.
  assign w_rd_sel = (i_rd_idx < BUF_CNT_W'(OAM_SCAN_MAX)) ? i_rd_idx : '0;
  assign w_wr_ok  = i_wr_en && (i_wr_idx < BUF_CNT_W'(OAM_SCAN_MAX));

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_obj_mem[i_wr_idx] <= i_wr_obj;
      r_idx_mem[i_wr_idx] <= i_wr_oam_idx;
    end
  end

  assign o_rd_obj     = r_obj_mem[w_rd_sel];
  assign o_rd_oam_idx = r_idx_mem[w_rd_sel];

endmodule

// File: rtl/gb_oam_scan.sv
// PPU mode-2 OAM scan: walks 40 objects at 2 cycles each, keeps the first 10 on the line.
// Build option: OAM_SCAN_DMA_BLOCK_EN rejects objects evaluated while OAM DMA is active.
module gb_oam_scan
  import gb_oam_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_start,
  input  logic [7:0]           ly_i,
  input  logic                 obj_size_i,
  input  logic                 dma_active,
  output logic [PPU_IDX_W-1:0] index_ppu_o,
  input  oam_obj_t             obj_i,
  output logic                 scan_busy,
  output logic                 scan_done,
  output logic [BUF_CNT_W-1:0] buf_count_o,
  input  logic [BUF_CNT_W-1:0] buf_rd_idx,
  output oam_obj_t             buf_obj_o,
  output logic [OAM_IDX_W-1:0] buf_oam_idx_o
);

  scan_state_t          r_state,     w_state_nxt;
  logic [OAM_IDX_W-1:0] r_obj_cnt,   w_obj_cnt_nxt;
  logic [BUF_CNT_W-1:0] r_buf_count, w_buf_count_nxt;
  logic [7:0]           r_ly,        w_ly_nxt;
  logic                 r_tall,      w_tall_nxt;
  logic                 r_busy,      w_busy_nxt;
  logic                 r_done,      w_done_nxt;
  logic [PPU_IDX_W-1:0] r_index,     w_index_nxt;
  logic                 w_hit;
  logic                 w_wr_en;

`ifdef OAM_SCAN_DMA_BLOCK_EN
  assign w_hit = obj_on_line(r_ly, r_tall, obj_i.y) && !dma_active;
`else
  logic w_unused_dma;
  assign w_unused_dma = dma_active;
  assign w_hit        = obj_on_line(r_ly, r_tall, obj_i.y);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SCAN_IDLE;
      r_obj_cnt   <= '0;
      r_buf_count <= '0;
      r_ly        <= '0;
      r_tall      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_index     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_obj_cnt   <= w_obj_cnt_nxt;
      r_buf_count <= w_buf_count_nxt;
      r_ly        <= w_ly_nxt;
      r_tall      <= w_tall_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_index     <= w_index_nxt;
    end
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    w_state_nxt     = r_state;
    w_obj_cnt_nxt   = r_obj_cnt;
    w_buf_count_nxt = r_buf_count;
    w_ly_nxt        = r_ly;
    w_tall_nxt      = r_tall;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_index_nxt     = '0;
    w_wr_en         = 1'b0;
    unique case (r_state)
      SCAN_IDLE: begin
        if (scan_start) begin
          w_ly_nxt        = ly_i;
          w_tall_nxt      = obj_size_i;
          w_buf_count_nxt = '0;
          w_obj_cnt_nxt   = '0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = SCAN_FETCH;
        end
      end
      SCAN_FETCH: begin
        w_busy_nxt  = 1'b1;
        w_index_nxt = PPU_IDX_W'(r_obj_cnt);
        w_state_nxt = SCAN_EVAL;
      end
      SCAN_EVAL: begin
        if (w_hit && (r_buf_count < BUF_CNT_W'(OAM_SCAN_MAX))) begin
          w_wr_en         = 1'b1;
          w_buf_count_nxt = r_buf_count + BUF_CNT_W'(1);
        end
        if (r_obj_cnt == OAM_IDX_W'(OAM_NUM_OBJS - 1)) begin
          w_obj_cnt_nxt = '0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = SCAN_DONE;
        end else begin
          w_obj_cnt_nxt = r_obj_cnt + OAM_IDX_W'(1);
          w_busy_nxt    = 1'b1;
          w_index_nxt   = PPU_IDX_W'(w_obj_cnt_nxt);
          w_state_nxt   = SCAN_FETCH;
        end
      end
      SCAN_DONE: begin
        w_state_nxt = SCAN_IDLE;
      end
      default: begin
        w_state_nxt = SCAN_IDLE;
      end
    endcase
  end

  gb_oam_scan_buf u_buf (
    .clk          (clk),
    .i_wr_en      (w_wr_en),
    .i_wr_idx     (r_buf_count),
    .i_wr_obj     (obj_i),
    .i_wr_oam_idx (r_obj_cnt),
    .i_rd_idx     (buf_rd_idx),
    .o_rd_obj     (buf_obj_o),
    .o_rd_oam_idx (buf_oam_idx_o)
  );

  assign index_ppu_o = r_index;
  assign scan_busy   = r_busy;
  assign scan_done   = r_done;
  assign buf_count_o = r_buf_count;

endmodule
